// File: rtl/asm_pkg.sv
// Shared MIPS32 encoding constants for the instruction assembler and the controller:
// mnemonic codes, major opcodes, function codes and word-packing helpers.
package asm_pkg;

  typedef enum logic [5:0] {
    MN_ADD   = 6'd0,  MN_ADDU  = 6'd1,  MN_SUB   = 6'd2,  MN_SUBU  = 6'd3,
    MN_AND   = 6'd4,  MN_OR    = 6'd5,  MN_XOR   = 6'd6,  MN_NOR   = 6'd7,
    MN_SLT   = 6'd8,  MN_SLTU  = 6'd9,  MN_SLL   = 6'd10, MN_SRL   = 6'd11,
    MN_SRA   = 6'd12, MN_ROTR  = 6'd13, MN_SLLV  = 6'd14, MN_SRLV  = 6'd15,
    MN_SRAV  = 6'd16, MN_ROTRV = 6'd17, MN_ADDI  = 6'd18, MN_ADDIU = 6'd19,
    MN_SLTI  = 6'd20, MN_SLTIU = 6'd21, MN_ANDI  = 6'd22, MN_ORI   = 6'd23,
    MN_XORI  = 6'd24, MN_LUI   = 6'd25, MN_CLZ   = 6'd26, MN_CLO   = 6'd27,
    MN_SEB   = 6'd28, MN_SEH   = 6'd29, MN_BEQ   = 6'd30, MN_BNE   = 6'd31,
    MN_BLEZ  = 6'd32, MN_BGTZ  = 6'd33, MN_BLTZ  = 6'd34, MN_BGEZ  = 6'd35,
    MN_J     = 6'd36
  } mnemonic_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } asm_state_e;

  localparam logic [5:0] OP_SPECIAL  = 6'b000000;
  localparam logic [5:0] OP_REGIMM   = 6'b000001;
  localparam logic [5:0] OP_J        = 6'b000010;
  localparam logic [5:0] OP_BEQ      = 6'b000100;
  localparam logic [5:0] OP_BNE      = 6'b000101;
  localparam logic [5:0] OP_BLEZ     = 6'b000110;
  localparam logic [5:0] OP_BGTZ     = 6'b000111;
  localparam logic [5:0] OP_ADDI     = 6'b001000;
  localparam logic [5:0] OP_ADDIU    = 6'b001001;
  localparam logic [5:0] OP_SLTI     = 6'b001010;
  localparam logic [5:0] OP_SLTIU    = 6'b001011;
  localparam logic [5:0] OP_ANDI     = 6'b001100;
  localparam logic [5:0] OP_ORI      = 6'b001101;
  localparam logic [5:0] OP_XORI     = 6'b001110;
  localparam logic [5:0] OP_LUI      = 6'b001111;
  localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
  localparam logic [5:0] OP_SPECIAL3 = 6'b011111;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_CLZ   = 6'b100000;
  localparam logic [5:0] FN_CLO   = 6'b100001;
  localparam logic [5:0] FN_BSHFL = 6'b100000;

  // Sub-opcode fields that select a variant within a shared opcode/func
  localparam logic [4:0] RT_BLTZ  = 5'b00000;
  localparam logic [4:0] RT_BGEZ  = 5'b00001;
  localparam logic [4:0] SA_SEB   = 5'b10000;
  localparam logic [4:0] SA_SEH   = 5'b11000;
  localparam logic [4:0] ROT_SEL  = 5'b00001;
  localparam logic [4:0] FIELD_Z  = 5'b00000;

  function automatic logic [31:0] r_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sa, input logic [5:0] fn);
    return {op, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational MIPS32 encoder: mnemonic plus operand fields to a 32-bit word.
// Fields a mnemonic does not use are forced to zero; unknown mnemonics clear legal.
module instr_pack
  import asm_pkg::*;
(
  input  logic [5:0]  mn,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  sa,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        legal
);

  // Encode the offered instruction
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (mn)
      MN_ADD:   word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_ADD);
      MN_ADDU:  word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_ADDU);
      MN_SUB:   word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SUB);
      MN_SUBU:  word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SUBU);
      MN_AND:   word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_AND);
      MN_OR:    word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_OR);
      MN_XOR:   word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_XOR);
      MN_NOR:   word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_NOR);
      MN_SLT:   word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SLT);
      MN_SLTU:  word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SLTU);
      MN_SLL:   word = r_word(OP_SPECIAL, FIELD_Z, rt, rd, sa, FN_SLL);
      MN_SRL:   word = r_word(OP_SPECIAL, FIELD_Z, rt, rd, sa, FN_SRL);
      MN_SRA:   word = r_word(OP_SPECIAL, FIELD_Z, rt, rd, sa, FN_SRA);
      // Rotates reuse the logical-right func; rs/sa bit 0 selects rotation
      MN_ROTR:  word = r_word(OP_SPECIAL, ROT_SEL, rt, rd, sa, FN_SRL);
      MN_SLLV:  word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SLLV);
      MN_SRLV:  word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SRLV);
      MN_SRAV:  word = r_word(OP_SPECIAL, rs, rt, rd, FIELD_Z, FN_SRAV);
      MN_ROTRV: word = r_word(OP_SPECIAL, rs, rt, rd, ROT_SEL, FN_SRLV);
      MN_ADDI:  word = i_word(OP_ADDI, rs, rt, imm);
      MN_ADDIU: word = i_word(OP_ADDIU, rs, rt, imm);
      MN_SLTI:  word = i_word(OP_SLTI, rs, rt, imm);
      MN_SLTIU: word = i_word(OP_SLTIU, rs, rt, imm);
      MN_ANDI:  word = i_word(OP_ANDI, rs, rt, imm);
      MN_ORI:   word = i_word(OP_ORI, rs, rt, imm);
      MN_XORI:  word = i_word(OP_XORI, rs, rt, imm);
      MN_LUI:   word = i_word(OP_LUI, FIELD_Z, rt, imm);
      // The ISA requires rt to repeat rd for the count-leading instructions
      MN_CLZ:   word = r_word(OP_SPECIAL2, rs, rd, rd, FIELD_Z, FN_CLZ);
      MN_CLO:   word = r_word(OP_SPECIAL2, rs, rd, rd, FIELD_Z, FN_CLO);
      MN_SEB:   word = r_word(OP_SPECIAL3, FIELD_Z, rt, rd, SA_SEB, FN_BSHFL);
      MN_SEH:   word = r_word(OP_SPECIAL3, FIELD_Z, rt, rd, SA_SEH, FN_BSHFL);
      MN_BEQ:   word = i_word(OP_BEQ, rs, rt, imm);
      MN_BNE:   word = i_word(OP_BNE, rs, rt, imm);
      MN_BLEZ:  word = i_word(OP_BLEZ, rs, FIELD_Z, imm);
      MN_BGTZ:  word = i_word(OP_BGTZ, rs, FIELD_Z, imm);
      MN_BLTZ:  word = i_word(OP_REGIMM, rs, RT_BLTZ, imm);
      MN_BGEZ:  word = i_word(OP_REGIMM, rs, RT_BGEZ, imm);
      MN_J:     word = j_word(OP_J, target);
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_assembler.sv
// Streaming MIPS32 assembler: encodes one symbolic instruction per cycle and writes
// the words sequentially into instruction memory starting at a programmable base.
module instr_assembler
  import asm_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_mn,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_sa,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic [ADDR_W:0]   prog_len,
  output logic              err_illegal
);

  // One past the last memory word; the extra counter bit keeps the address from wrapping
  localparam logic [ADDR_W:0] ADDR_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_W    = {{ADDR_W{1'b0}}, 1'b1};

  asm_state_e        state_r;
  asm_state_e        state_nxt_s;
  logic [ADDR_W:0]   addr_r;
  logic [ADDR_W:0]   addr_inc_s;
  logic [ADDR_W:0]   count_r;
  logic              ready_r;
  logic              we_r;
  logic [ADDR_W-1:0] waddr_r;
  logic [31:0]       wdata_r;
  logic              done_r;
  logic [ADDR_W:0]   prog_len_r;
  logic              err_r;
  logic [31:0]       pack_word_s;
  logic              pack_legal_s;
  logic              accept_s;
  logic              write_s;
  logic              start_take_s;

  instr_pack u_pack (
    .mn     (in_mn),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .sa     (in_sa),
    .imm    (in_imm),
    .target (in_target),
    .word   (pack_word_s),
    .legal  (pack_legal_s)
  );

  // Handshake qualifiers and the next write address
  always_comb begin
    accept_s     = in_valid && ready_r;
    write_s      = accept_s && pack_legal_s;
    start_take_s = (state_r == ST_IDLE) && start;
    addr_inc_s   = addr_r + ONE_W;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt_s = ST_DRAIN;
        end else if (write_s && (addr_inc_s == ADDR_END)) begin
          state_nxt_s = ST_FULL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FULL: begin
        if (stop) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FULL;
        end
      end
      ST_DRAIN: state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register with registered ready and done derived from state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_RUN);
      done_r  <= (state_r == ST_DRAIN);
    end
  end

  // Address/count bookkeeping and the write stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r     <= '0;
      count_r    <= '0;
      we_r       <= 1'b0;
      waddr_r    <= '0;
      wdata_r    <= 32'h0000_0000;
      prog_len_r <= '0;
    end else begin
      we_r <= write_s;
      if (start_take_s) begin
        addr_r  <= {1'b0, base_addr};
        count_r <= '0;
      end else if (write_s) begin
        waddr_r <= addr_r[ADDR_W-1:0];
        wdata_r <= pack_word_s;
        addr_r  <= addr_inc_s;
        count_r <= count_r + ONE_W;
      end
      if (state_r == ST_DRAIN) begin
        prog_len_r <= count_r;
      end
    end
  end

  // Sticky illegal-mnemonic flag, cleared when a new program starts
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (start_take_s) begin
      err_r <= 1'b0;
    end else if (accept_s && !pack_legal_s) begin
      err_r <= 1'b1;
    end
  end

  assign in_ready    = ready_r;
  assign imem_we     = we_r;
  assign imem_addr   = waddr_r;
  assign imem_wdata  = wdata_r;
  assign done        = done_r;
  assign prog_len    = prog_len_r;
  assign err_illegal = err_r;

endmodule

// File: tb/tb_instr_assembler.sv
// Scoreboard bench for instr_assembler: stimulus pushes expected writes and program
// lengths; a negedge monitor pops and compares whenever imem_we or done is seen.
module tb_instr_assembler;
  import asm_pkg::*;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          stop = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [5:0]    in_mn = 6'd0;
  logic [4:0]    in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0, in_sa = 5'd0;
  logic [15:0]   in_imm = 16'd0;
  logic [25:0]   in_target = 26'd0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          done;
  logic [AW:0]   prog_len;
  logic          err_illegal;

  always #5 clk = ~clk;

  instr_assembler #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_mn(in_mn), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_sa(in_sa), .in_imm(in_imm),
    .in_target(in_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .prog_len(prog_len),
    .err_illegal(err_illegal)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [AW-1:0] exp_addr_q[$];
  logic [31:0]   exp_data_q[$];
  logic [AW:0]   exp_len_q[$];
  logic [AW-1:0] mon_addr;
  logic [31:0]   mon_data;
  logic [AW:0]   mon_len;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every write strobe and done pulse must match the head of its queue
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_data_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h with nothing expected",
                 imem_addr, imem_wdata);
      end else begin
        mon_addr = exp_addr_q.pop_front();
        mon_data = exp_data_q.pop_front();
        check("wr_addr", 32'(imem_addr), 32'(mon_addr));
        check("wr_data", imem_wdata, mon_data);
      end
    end
    if (done) begin
      if (exp_len_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: prog_len %0d with nothing expected", prog_len);
      end else begin
        mon_len = exp_len_q.pop_front();
        check("prog_len", 32'(prog_len), 32'(mon_len));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_prog(input logic [AW-1:0] b);
    start = 1'b1;
    base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic issue(input logic [5:0] mn, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                       input logic [25:0] tg, input logic wr, input logic [AW-1:0] ea,
                       input logic [31:0] ed, input logic with_stop);
    check("in_ready_before_issue", 32'(in_ready), 32'd1);
    in_mn = mn; in_rs = rs; in_rt = rt; in_rd = rd; in_sa = sa;
    in_imm = imm; in_target = tg;
    in_valid = 1'b1;
    stop = with_stop;
    if (wr) begin
      exp_addr_q.push_back(ea);
      exp_data_q.push_back(ed);
    end
    tick();
    in_valid = 1'b0;
    stop = 1'b0;
  endtask

  task automatic end_prog(input logic [AW:0] len);
    exp_len_q.push_back(len);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err_illegal), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_prog_len"}, 32'(prog_len), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check_reset_values("reset");

    // ADD rd=3 rs=1 rt=2 alone
    begin_prog(4'd0);
    issue(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 4'd0, 32'h0022_1820, 1'b0);
    check("we_next_cycle", 32'(imem_we), 32'd1);
    end_prog(5'd1);

    // Back-to-back stream with junk in unused fields; start mid-run must be ignored
    begin_prog(4'd0);
    issue(MN_ADDI, 5'd0, 5'd8, 5'd31, 5'd31, 16'hFFFF, 26'h3FF_FFFF, 1'b1, 4'd0, 32'h2008_FFFF, 1'b0);
    start = 1'b1;
    base_addr = 4'd9;
    issue(MN_ROTR, 5'd9, 5'd5, 5'd4, 5'd3, 16'hABCD, 26'h0, 1'b1, 4'd1, 32'h0025_20C2, 1'b0);
    start = 1'b0;
    issue(MN_LUI, 5'd5, 5'd9, 5'd7, 5'd2, 16'h1234, 26'h0, 1'b1, 4'd2, 32'h3C09_1234, 1'b0);
    issue(MN_CLZ, 5'd3, 5'd31, 5'd2, 5'd4, 16'h0, 26'h0, 1'b1, 4'd3, 32'h7062_1020, 1'b0);
    issue(MN_SEB, 5'd1, 5'd7, 5'd6, 5'd0, 16'h0, 26'h0, 1'b1, 4'd4, 32'h7C07_3420, 1'b0);
    end_prog(5'd5);

    // Branch then jump with stop in the same cycle
    begin_prog(4'd0);
    issue(MN_BGEZ, 5'd7, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0, 1'b1, 4'd0, 32'h04E1_0010, 1'b0);
    exp_len_q.push_back(5'd2);
    issue(MN_J, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h010_0040, 1'b1, 4'd1, 32'h0810_0040, 1'b1);
    check("last_we", 32'(imem_we), 32'd1);
    tick();
    check("done_after_last_write", 32'(done), 32'd1);
    tick();
    check("done_single_pulse", 32'(done), 32'd0);

    // Fill the top of memory: base 14 allows two words, the third must stall
    begin_prog(4'd14);
    issue(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 4'd14, 32'h0022_1820, 1'b0);
    issue(MN_SUB, 5'd5, 5'd6, 5'd4, 5'd0, 16'h0, 26'h0, 1'b1, 4'd15, 32'h00A6_2022, 1'b0);
    in_mn = MN_ADD;
    in_valid = 1'b1;
    check("full_ready_low", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("full_ready_stays_low", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    end_prog(5'd2);

    // Undefined mnemonic between two ADDs
    begin_prog(4'd0);
    issue(MN_ADD, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b1, 4'd0, 32'h0022_1820, 1'b0);
    issue(6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0, 4'd0, 32'h0, 1'b0);
    check("err_set", 32'(err_illegal), 32'd1);
    issue(MN_ADD, 5'd6, 5'd5, 5'd7, 5'd0, 16'h0, 26'h0, 1'b1, 4'd1, 32'h00C5_3820, 1'b0);
    end_prog(5'd2);
    check("err_sticky", 32'(err_illegal), 32'd1);
    begin_prog(4'd0);
    check("err_cleared_by_start", 32'(err_illegal), 32'd0);

    // Reset raised on the edge that would register an accept: no write follows
    check("ready_before_rst", 32'(in_ready), 32'd1);
    in_mn = MN_ADD;
    in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    in_valid = 1'b1;
    rst = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b0;
    check_reset_values("mid_rst");
    tick();
    check("mid_rst_no_late_we", 32'(imem_we), 32'd0);
    check("mid_rst_idle", 32'(in_ready), 32'd0);

    tick();
    check("pending_writes", 32'(exp_data_q.size()), 32'd0);
    check("pending_dones", 32'(exp_len_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
